// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback stage and the multi-cycle mul/div unit. Mul/div results are
//   buffered in a DEPTH-entry FIFO; the pipeline has priority. A 32-bit
//   pending scoreboard tracks registers whose mul/div result has not yet
//   been written, so decode can stall on Rs/Rt.
//
//   Optional build macro WB_STARVE_GUARD_EN: when defined, a starve counter
//   forces the FIFO head through after STARVE_LIMIT consecutive lost
//   arbitrations and raises wb_stall for that cycle. Undefined: strict
//   pipeline priority and wb_stall tied 0.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   wb_we/wb_addr/wb_data           pipeline writeback request
//   wb_stall                        pipeline write refused this cycle
//   md_issue/md_issue_addr          mul/div op issued (marks dest pending)
//   md_valid/md_addr/md_data        mul/div result, handshake with md_ready
//   md_ready                        FIFO has room
//   rs_addr/rt_addr                 decode source registers
//   rs_busy/rt_busy                 source has a pending mul/div write
//   rf_we/rf_addr/rf_data           registered register-file write port
module regfile_write_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             wb_stall,
  input  logic             md_issue,
  input  logic [4:0]       md_issue_addr,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_addr,
  input  logic [WIDTH-1:0] md_data,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [WIDTH-1:0] rf_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Reject illegal configurations at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("regfile_write_arbiter: DEPTH must be a power of 2 >= 2, STARVE_LIMIT >= 1");
  end

  // FIFO storage (no reset needed: validity is tracked by count_q)
  logic [4:0]       fifo_addr_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sb_q, sb_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;

  logic             pipe_req;
  logic             fifo_nonempty;
  logic             push;
  logic             pop;
  logic             pipe_grant;
  logic             force_fifo;
  logic [4:0]       head_addr;
  logic [WIDTH-1:0] head_data;

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            wb_stall_q, wb_stall_d;

  // The registered stall marks the cycle in which the FIFO head is forced.
  assign force_fifo = wb_stall_q && fifo_nonempty;
  assign wb_stall   = wb_stall_q;
`else
  assign force_fifo = 1'b0;
  assign wb_stall   = 1'b0;
`endif

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    // Register 0 is hardwired: writes to it are not requests.
    pipe_req      = wb_we && (wb_addr != 5'd0);
    fifo_nonempty = (count_q != '0);
    // Ready comes from the registered count only; no pass-through when full.
    md_ready      = (count_q != CNT_W'(DEPTH));
    // Results to r0 complete the handshake but are dropped.
    push          = md_valid && md_ready && (md_addr != 5'd0);
    pipe_grant    = pipe_req && !force_fifo;
    pop           = fifo_nonempty && !pipe_grant;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Clear on grant first so a same-cycle issue to that register wins.
    sb_d = sb_q;
    if (pop) sb_d[head_addr] = 1'b0;
    if (md_issue && (md_issue_addr != 5'd0)) sb_d[md_issue_addr] = 1'b1;

    rf_we_d   = pipe_grant || pop;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pipe_grant) begin
      rf_addr_d = wb_addr;
      rf_data_d = wb_data;
    end else if (pop) begin
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end

    rs_busy = (rs_addr != 5'd0) && sb_q[rs_addr];
    rt_busy = (rt_addr != 5'd0) && sb_q[rt_addr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= md_addr;
      fifo_data_q[wr_ptr_q] <= md_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sb_q      <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sb_q      <= sb_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  always_comb begin
    // Count cycles the FIFO waits behind the pipeline; any FIFO win or an
    // empty FIFO restarts the count.
    if (fifo_nonempty && pipe_grant) starve_cnt_d = starve_cnt_q + SC_W'(1);
    else                             starve_cnt_d = '0;
    wb_stall_d = (starve_cnt_d == SC_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      wb_stall_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wb_stall_q   <= wb_stall_d;
    end
  end
`endif

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int WIDTH        = 32;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_stall;
  logic             md_issue;
  logic [4:0]       md_issue_addr;
  logic             md_valid;
  logic             md_ready;
  logic [4:0]       md_addr;
  logic [WIDTH-1:0] md_data;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic             rs_busy;
  logic             rt_busy;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [WIDTH-1:0] rf_data;

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_issue(md_issue), .md_issue_addr(md_issue_addr),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0]       mq_addr [$];
  logic [WIDTH-1:0] mq_data [$];
  bit   [31:0]      msb;
  bit               e_we;
  logic [4:0]       e_addr;
  logic [WIDTH-1:0] e_data;
  int               m_cnt;
  bit               m_stall;

  task automatic model_reset();
    mq_addr.delete();
    mq_data.delete();
    msb = '0; e_we = 0; e_addr = '0; e_data = '0; m_cnt = 0; m_stall = 0;
  endtask

  // One clock of the arbitration rules, applied to the current inputs.
  task automatic model_step();
    bit pipe, nonempty, full, pipe_won;
    pipe     = wb_we && (wb_addr != 5'd0);
    nonempty = (mq_addr.size() != 0);
    full     = (mq_addr.size() == DEPTH);
    pipe_won = 0;
    if (pipe && !m_stall) begin
      e_we = 1; e_addr = wb_addr; e_data = wb_data; pipe_won = 1;
    end else if (nonempty) begin
      e_we = 1; e_addr = mq_addr.pop_front(); e_data = mq_data.pop_front();
      msb[e_addr] = 0;
    end else begin
      e_we = 0;
    end
    if (md_issue && md_issue_addr != 5'd0) msb[md_issue_addr] = 1;
    if (md_valid && !full && md_addr != 5'd0) begin
      mq_addr.push_back(md_addr);
      mq_data.push_back(md_data);
    end
`ifdef WB_STARVE_GUARD_EN
    if (nonempty && pipe_won) m_cnt++;
    else                      m_cnt = 0;
    m_stall = (m_cnt == STARVE_LIMIT);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = '0; wb_data = '0;
    md_issue = 0; md_issue_addr = '0;
    md_valid = 0; md_addr = '0; md_data = '0;
    rs_addr = '0; rt_addr = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_addr !== 5'd0) begin failures++; $display("FAIL reset_rf_addr got=%0d exp=0", rf_addr); end
    checks++; if (rf_data !== '0) begin failures++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL reset_md_ready got=%b exp=1", md_ready); end
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_wb_stall got=%b exp=0", wb_stall); end
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", rs_busy, rt_busy); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h1;
    md_issue = 1; md_issue_addr = 5'd5;
    tick();
    md_issue = 0;
    md_valid = 1; md_addr = 5'd5; md_data = 32'h55;
    tick();
    md_addr = 5'd6; md_data = 32'h66;
    tick();
    md_valid = 0; wb_we = 0; rs_addr = 5'd5;
    #1;
    checks++; if (rs_busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", rs_busy); end
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midrst_rf_we got=%b exp=0", rf_we); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL midrst_md_ready got=%b exp=1", md_ready); end
    checks++; if (rs_busy !== 1'b0) begin failures++; $display("FAIL midrst_rs_busy got=%b exp=0", rs_busy); end
    @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midrst_no_write cyc=%0d got=%b exp=0", k, rf_we); end
    end
  endtask

  task automatic test_pipe_write();
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'h1234;
    tick();
    wb_we = 0;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h1234) begin
      failures++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/3/1234", rf_we, rf_addr, rf_data); end
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    tick();
    wb_we = 0;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL pipe_r0 got=%b exp=0", rf_we); end
    checks++; if (rf_addr !== 5'd3 || rf_data !== 32'h1234) begin
      failures++; $display("FAIL pipe_hold got=%0d/%h exp=3/1234", rf_addr, rf_data); end
  endtask

  task automatic test_md_scoreboard();
    md_issue = 1; md_issue_addr = 5'd7;
    tick();
    md_issue = 0; rs_addr = 5'd7; rt_addr = 5'd8;
    #1;
    checks++; if (rs_busy !== 1'b1 || rt_busy !== 1'b0) begin
      failures++; $display("FAIL md_busy_set got=%b%b exp=10", rs_busy, rt_busy); end
    md_valid = 1; md_addr = 5'd7; md_data = 32'hBEEF;
    tick();
    md_valid = 0;
    checks++; if (rf_we !== 1'b0 || rs_busy !== 1'b1) begin
      failures++; $display("FAIL md_pushed got=we%b busy%b exp=we0 busy1", rf_we, rs_busy); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'hBEEF) begin
      failures++; $display("FAIL md_write got=%b/%0d/%h exp=1/7/beef", rf_we, rf_addr, rf_data); end
    checks++; if (rs_busy !== 1'b0) begin failures++; $display("FAIL md_busy_clear got=%b exp=0", rs_busy); end
    md_issue = 1; md_issue_addr = 5'd0; rs_addr = 5'd0;
    tick();
    md_issue = 0;
    checks++; if (rs_busy !== 1'b0) begin failures++; $display("FAIL md_issue_r0 got=%b exp=0", rs_busy); end
  endtask

  task automatic test_fifo_full();
    wb_we = 1; wb_addr = 5'd2; wb_data = 32'h22;
    md_valid = 1;
    for (int k = 0; k < DEPTH; k++) begin
      md_addr = 5'(10 + k); md_data = 32'(8'hA0 + k);
      #1;
      checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, md_ready); end
      tick();
    end
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", md_ready); end
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd2) begin
      failures++; $display("FAIL full_pipe got=%b/%0d exp=1/2", rf_we, rf_addr); end
    md_addr = 5'd14; md_data = 32'hAE;
    tick();
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready got=%b exp=0", md_ready); end
    md_valid = 0; wb_we = 0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      checks++; if (rf_we !== 1'b1 || rf_addr !== 5'(10 + k) || rf_data !== 32'(8'hA0 + k)) begin
        failures++; $display("FAIL drain k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rf_we, rf_addr, rf_data, 10 + k, 8'hA0 + k); end
      if (k == 0) begin
        checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL pop_ready got=%b exp=1", md_ready); end
      end
    end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", rf_we); end
  endtask

  task automatic test_priority();
    wb_we = 1; wb_addr = 5'd8; wb_data = 32'h88;
    md_valid = 1; md_addr = 5'd20; md_data = 32'h2020;
    tick();
    md_valid = 0; wb_addr = 5'd9; wb_data = 32'h99;
    tick();
    wb_we = 0;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'h99) begin
      failures++; $display("FAIL prio_pipe got=%b/%0d/%h exp=1/9/99", rf_we, rf_addr, rf_data); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd20 || rf_data !== 32'h2020) begin
      failures++; $display("FAIL prio_fifo got=%b/%0d/%h exp=1/20/2020", rf_we, rf_addr, rf_data); end
    md_valid = 1; md_addr = 5'd0; md_data = 32'hCAFE;
    #1;
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", md_ready); end
    tick();
    md_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_dropped k=%0d got=%b exp=0", k, rf_we); end
    end
  endtask

`ifdef WB_STARVE_GUARD_EN
  task automatic test_starve();
    apply_reset();
    wb_we = 1; wb_addr = 5'd4; wb_data = 32'h44;
    md_valid = 1; md_addr = 5'd15; md_data = 32'hF00D;
    for (int k = 1; k <= STARVE_LIMIT + 1; k++) begin
      tick();
      md_valid = 0;
      checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4) begin
        failures++; $display("FAIL starve_pipe k=%0d got=%b/%0d exp=1/4", k, rf_we, rf_addr); end
      checks++; if (wb_stall !== (k == STARVE_LIMIT + 1)) begin
        failures++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, wb_stall, k == STARVE_LIMIT + 1); end
    end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd15 || rf_data !== 32'hF00D) begin
      failures++; $display("FAIL starve_forced got=%b/%0d/%h exp=1/15/f00d", rf_we, rf_addr, rf_data); end
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL starve_release got=%b exp=0", wb_stall); end
    tick();
    wb_we = 0;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h44) begin
      failures++; $display("FAIL starve_held_wb got=%b/%0d/%h exp=1/4/44", rf_we, rf_addr, rf_data); end
  endtask
`endif

  task automatic test_random();
    logic [4:0] a;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!wb_stall) begin
        wb_we   = (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
        wb_addr = 5'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      md_valid = ($urandom_range(0, 2) != 0);
      md_addr  = 5'($urandom_range(0, 31));
      md_data  = $urandom;
      a = 5'($urandom_range(0, 31));
      md_issue = ($urandom_range(0, 1) == 1) && !msb[a];
      md_issue_addr = a;
      rs_addr = 5'($urandom_range(0, 31));
      rt_addr = 5'($urandom_range(0, 31));
      #1;
      checks++; if (md_ready !== (mq_addr.size() != DEPTH)) begin
        failures++; $display("FAIL rnd_md_ready i=%0d got=%b exp=%b", i, md_ready, mq_addr.size() != DEPTH); end
      checks++; if (rs_busy !== msb[rs_addr] || rt_busy !== msb[rt_addr]) begin
        failures++; $display("FAIL rnd_busy i=%0d got=%b%b exp=%b%b", i, rs_busy, rt_busy, msb[rs_addr], msb[rt_addr]); end
      tick();
      checks++; if (rf_we !== e_we || rf_addr !== e_addr || rf_data !== e_data) begin
        failures++; $display("FAIL rnd_write i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we, rf_addr, rf_data, e_we, e_addr, e_data); end
      checks++; if (wb_stall !== m_stall) begin
        failures++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, wb_stall, m_stall); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    #12;
    test_reset();
    test_pipe_write();
    test_md_scoreboard();
    test_fifo_full();
    test_priority();
    test_reset_mid();
`ifdef WB_STARVE_GUARD_EN
    test_starve();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the pipeline writeback stage and the multi-cycle mul/div unit.
- Buffers mul/div results in a small FIFO and drives the registered write port (rf_we/rf_addr/rf_data).
- Keeps a per-register pending scoreboard so decode can stall on Rs/Rt whose mul/div result has not yet been written.
- Sits between WB stage, mul/div unit and the register file.

Parameters:
WIDTH, 32, data width of register file entries
DEPTH, 4, mul/div result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive lost arbitrations before FIFO is forced a slot (optional feature only)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
wb_we  input  1  pipeline writeback request
wb_addr  input  5  pipeline destination register
wb_data  input  WIDTH  pipeline write data
wb_stall  output  1  pipeline write not accepted this cycle; WB must hold request
md_issue  input  1  mul/div accepted an op this cycle
md_issue_addr  input  5  destination of issued op
md_valid  input  1  mul/div result valid
md_ready  output  1  FIFO can accept a result
md_addr  input  5  result destination
md_data  input  WIDTH  result data
rs_addr  input  5  decode Rs
rt_addr  input  5  decode Rt
rs_busy  output  1  Rs has pending mul/div write
rt_busy  output  1  Rt has pending mul/div write
rf_we  output  1  register file write enable (registered)
rf_addr  output  5  register file write address (registered)
rf_data  output  WIDTH  register file write data (registered)

Behaviour:
- Reset (async, rst=1): FIFO empty, count 0, scoreboard all 0, rf_we=0, rf_addr=0, rf_data=0, wb_stall=0, starve counter 0. md_ready=1 after reset; rs_busy/rt_busy=0.
- Register 0 is hardwired: wb_we with wb_addr=0 is no request; md result with md_addr=0 is accepted (handshake completes) but not stored; md_issue to addr 0 sets nothing.
- FIFO push when md_valid && md_ready; md_ready = (count != DEPTH), derived from registered count only (no pass-through when full, even if popping same cycle). Push and pop in the same cycle allowed when not full; count unchanged. Pointers wrap mod DEPTH.
- Arbitration per cycle (priority, no macro): pipeline request wins; else FIFO head popped if non-empty; else idle.
- Write port registered: grant in cycle N -> rf_we/rf_addr/rf_data valid in cycle N+1; rf_we=0 on idle cycles (rf_addr/rf_data hold).
- Scoreboard: 32 bits. md_issue sets bit[md_issue_addr] next edge. Bit cleared on the edge at which a FIFO head is granted to that address. Same-address set and clear in one cycle: set wins. Pipeline writes never touch the scoreboard. Two outstanding issues to one register is illegal (bench assertion).
- rs_busy = scoreboard[rs_addr], rt_busy = scoreboard[rt_addr], combinational from registered state; addr 0 always 0.
- wb_stall = 0 without the optional feature.
- Reset mid-operation discards FIFO contents and scoreboard; no write emitted.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined: starve counter increments each cycle the FIFO is non-empty and the pipeline wins. It clears when the FIFO is empty or the FIFO wins. When the counter reaches STARVE_LIMIT:
  - next cycle wb_stall=1 (registered) and the FIFO head wins regardless of wb_we;
  - the pipeline request that cycle is not written, and WB holds it;
  - the counter clears.
- Undefined: no counter; wb_stall tied 0; strict pipeline priority.

Test Plan:
- Reset: assert rst mid-traffic with 2 FIFO entries, scoreboard bit 5 set -> rf_we=0, md_ready=1, rs_busy(rs_addr=5)=0 immediately.
- Pipeline write wb_addr=3, wb_data=0x1234 in cycle N -> rf_we=1, rf_addr=3, rf_data=0x1234 in N+1. wb_addr=0 -> rf_we=0.
- md_issue addr 7 -> rs_busy=1 for rs_addr=7. Push result (7, 0xBEEF) with no WB traffic -> written one cycle after grant; rs_busy drops the same edge the grant registers.
- Fill FIFO with 4 results while wb_we held 1 -> md_ready=0 after 4th push. Release wb_we -> entries written in order, one per cycle; md_ready=1 after first pop.
- Simultaneous wb_we (addr 9) and non-empty FIFO -> pipeline written first, FIFO head next idle cycle. md result to addr 0 -> accepted, never written.
- WB_STARVE_GUARD_EN, STARVE_LIMIT=8, wb_we held with FIFO non-empty -> after 8 pipeline grants, wb_stall=1 for one cycle and FIFO head written; held WB data written the following cycle.
